// File: rtl/npc_predict_unit.sv
// Next-PC unit: owns the fetch PC, predicts beq/bne with a 2-bit BHT,
// follows j/jal in F and resolves branches and jr in D.
module npc_predict_unit #(
    parameter int         WIDTH       = 32,
    parameter int         BHT_ENTRIES = 64,
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [1:0] CNT_INIT    = 2'b01
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr_F,
    input  logic             stall,
    input  logic             branch_D,
    input  logic             taken_D,
    input  logic             jr_D,
    input  logic [WIDTH-1:0] RD1,
    output logic [WIDTH-1:0] PC_F,
    output logic             flush_F,
    output logic             pred_taken_F,
    output logic [31:0]      branch_cnt,
    output logic [31:0]      mispred_cnt
);

    localparam int IDXW = $clog2(BHT_ENTRIES);

    logic [1:0]       bht [BHT_ENTRIES];
    logic             valid_D;
    logic             pred_D;
    logic [WIDTH-1:0] pc_D;
    logic [WIDTH-1:0] off_D;

    logic [5:0]       opcode;
    logic             is_br_f;
    logic             is_j_f;
    logic [IDXW-1:0]  idx_f;
    logic [IDXW-1:0]  idx_d;
    logic [WIDTH-1:0] seq;
    logic [WIDTH-1:0] off_f;
    logic [WIDTH-1:0] npred;
    logic [WIDTH-1:0] pc_next;
    logic             res;
    logic             mis;
    logic             jr_r;
    logic [1:0]       cnt_cur;
    logic [1:0]       cnt_upd;

    assign opcode  = instr_F[31:26];
    assign is_br_f = (opcode == 6'b000100) || (opcode == 6'b000101);
    assign is_j_f  = (opcode == 6'b000010) || (opcode == 6'b000011);
    assign idx_f   = PC_F[IDXW+1:2];
    assign idx_d   = pc_D[IDXW+1:2];
    assign seq     = PC_F + WIDTH'(4);
    assign off_f   = {{(WIDTH-18){instr_F[15]}}, instr_F[15:0], 2'b00};

    assign pred_taken_F = is_br_f & bht[idx_f][1];

    always_comb begin
        npred = seq;
        unique case (1'b1)
            pred_taken_F: npred = seq + off_f;
            is_j_f:       npred = {seq[WIDTH-1:28], instr_F[25:0], 2'b00};
            default:      npred = seq;
        endcase
    end

    assign res     = valid_D & branch_D & ~stall;
    assign mis     = res & (taken_D != pred_D);
    assign jr_r    = jr_D & ~stall;
    assign flush_F = jr_r | mis;

    // D-stage redirects take precedence over anything predicted in F
    always_comb begin
        pc_next = npred;
        if (stall)
            pc_next = PC_F;
        else if (jr_r)
            pc_next = RD1;
        else if (mis && taken_D)
            pc_next = pc_D + WIDTH'(4) + off_D;
        else if (mis)
            pc_next = pc_D + WIDTH'(4);
    end

    assign cnt_cur = bht[idx_d];

    always_comb begin
        cnt_upd = cnt_cur;
        if (taken_D) begin
            if (cnt_cur != 2'b11)
                cnt_upd = cnt_cur + 2'b01;
        end else begin
            if (cnt_cur != 2'b00)
                cnt_upd = cnt_cur - 2'b01;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            PC_F    <= WIDTH'(RESET_PC);
            valid_D <= 1'b0;
            pred_D  <= 1'b0;
            pc_D    <= '0;
            off_D   <= '0;
        end else begin
            PC_F <= pc_next;
            if (!stall) begin
                valid_D <= is_br_f & ~flush_F;
                pred_D  <= pred_taken_F;
                pc_D    <= PC_F;
                off_D   <= off_f;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BHT_ENTRIES; i++)
                bht[i] <= CNT_INIT;
        end else if (res) begin
            bht[idx_d] <= cnt_upd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            if (res)
                branch_cnt <= branch_cnt + 32'd1;
            if (mis)
                mispred_cnt <= mispred_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_npc_predict_unit.sv
// Directed bench for npc_predict_unit: reset, j, BHT training,
// stalls, jr redirect and mid-run reset.
module tb_npc_predict_unit;

    localparam logic [31:0] NOP    = 32'h0000_0000;
    localparam logic [31:0] J_FWD  = 32'h0800_0C10;
    localparam logic [31:0] J_BACK = 32'h0800_0C00;
    localparam logic [31:0] BEQ3   = 32'h1000_0003;
    localparam logic [31:0] BNE_M2 = 32'h1400_FFFE;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr_F;
    logic        stall;
    logic        branch_D;
    logic        taken_D;
    logic        jr_D;
    logic [31:0] RD1;
    logic [31:0] PC_F;
    logic        flush_F;
    logic        pred_taken_F;
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    npc_predict_unit dut (
        .clk          (clk),
        .reset        (reset),
        .instr_F      (instr_F),
        .stall        (stall),
        .branch_D     (branch_D),
        .taken_D      (taken_D),
        .jr_D         (jr_D),
        .RD1          (RD1),
        .PC_F         (PC_F),
        .flush_F      (flush_F),
        .pred_taken_F (pred_taken_F),
        .branch_cnt   (branch_cnt),
        .mispred_cnt  (mispred_cnt)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        instr_F  = NOP;
        stall    = 1'b0;
        branch_D = 1'b0;
        taken_D  = 1'b0;
        jr_D     = 1'b0;
        RD1      = 32'h0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        clear_inputs();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        int bad;
        reset = 1'b1;
        clear_inputs();
        #12;
        n_checks++;
        if (PC_F !== 32'h3000) begin
            n_fail++;
            $display("FAIL reset_pc: got %h exp 00003000", PC_F);
        end
        n_checks++;
        if (branch_cnt !== 0 || mispred_cnt !== 0) begin
            n_fail++;
            $display("FAIL reset_cnt: got %0d/%0d exp 0/0", branch_cnt, mispred_cnt);
        end
        n_checks++;
        if (flush_F !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flush: got %b exp 0", flush_F);
        end
        bad = 0;
        for (int i = 0; i < 64; i++)
            if (dut.bht[i] !== 2'b01) bad++;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL reset_bht: %0d entries differ from 01", bad);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_nop_stream();
        for (int i = 0; i < 4; i++) begin
            instr_F = NOP;
            #1;
            n_checks++;
            if (PC_F !== 32'h3000 + 32'(4 * i) || flush_F !== 1'b0) begin
                n_fail++;
                $display("FAIL nop_seq[%0d]: pc %h flush %b exp pc %h flush 0",
                         i, PC_F, flush_F, 32'h3000 + 32'(4 * i));
            end
            @(negedge clk);
        end
        n_checks++;
        if (branch_cnt !== 0 || mispred_cnt !== 0) begin
            n_fail++;
            $display("FAIL nop_cnt: got %0d/%0d exp 0/0", branch_cnt, mispred_cnt);
        end
    endtask

    task automatic test_jump();
        do_reset();
        instr_F = J_FWD;
        #1;
        n_checks++;
        if (pred_taken_F !== 1'b0 || flush_F !== 1'b0) begin
            n_fail++;
            $display("FAIL j_comb: pred %b flush %b exp 0 0", pred_taken_F, flush_F);
        end
        @(negedge clk);
        n_checks++;
        if (PC_F !== 32'h0000_3040) begin
            n_fail++;
            $display("FAIL j_target: got %h exp 00003040", PC_F);
        end
        instr_F = NOP;
        #1;
        n_checks++;
        if (flush_F !== 1'b0) begin
            n_fail++;
            $display("FAIL j_noflush: got %b exp 0", flush_F);
        end
        @(negedge clk);
    endtask

    task automatic test_mispredict();
        do_reset();
        instr_F = BEQ3;
        #1;
        n_checks++;
        if (pred_taken_F !== 1'b0) begin
            n_fail++;
            $display("FAIL mp_pred: got %b exp 0", pred_taken_F);
        end
        @(negedge clk);
        n_checks++;
        if (PC_F !== 32'h3004) begin
            n_fail++;
            $display("FAIL mp_seq: got %h exp 00003004", PC_F);
        end
        instr_F  = NOP;
        branch_D = 1'b1;
        taken_D  = 1'b1;
        #1;
        n_checks++;
        if (flush_F !== 1'b1) begin
            n_fail++;
            $display("FAIL mp_flush: got %b exp 1", flush_F);
        end
        @(negedge clk);
        branch_D = 1'b0;
        taken_D  = 1'b0;
        n_checks++;
        if (PC_F !== 32'h3010) begin
            n_fail++;
            $display("FAIL mp_redirect: got %h exp 00003010", PC_F);
        end
        n_checks++;
        if (dut.bht[0] !== 2'b10) begin
            n_fail++;
            $display("FAIL mp_bht: got %b exp 10", dut.bht[0]);
        end
        n_checks++;
        if (branch_cnt !== 1 || mispred_cnt !== 1) begin
            n_fail++;
            $display("FAIL mp_cnt: got %0d/%0d exp 1/1", branch_cnt, mispred_cnt);
        end
    endtask

    task automatic test_train();
        logic [1:0] cnt;
        logic       p;
        int         nb;
        int         nm;
        cnt = 2'b10;
        nb  = 1;
        nm  = 1;
        instr_F = J_BACK;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            p = cnt[1];
            instr_F = BEQ3;
            #1;
            n_checks++;
            if (PC_F !== 32'h3000 || pred_taken_F !== p) begin
                n_fail++;
                $display("FAIL train_pred[%0d]: pc %h pred %b exp 00003000 %b",
                         k, PC_F, pred_taken_F, p);
            end
            @(negedge clk);
            instr_F  = J_BACK;
            branch_D = 1'b1;
            taken_D  = 1'b1;
            #1;
            n_checks++;
            if (PC_F !== (p ? 32'h3010 : 32'h3004) || flush_F !== !p) begin
                n_fail++;
                $display("FAIL train_res[%0d]: pc %h flush %b exp pc %h flush %b",
                         k, PC_F, flush_F, p ? 32'h3010 : 32'h3004, !p);
            end
            @(negedge clk);
            branch_D = 1'b0;
            taken_D  = 1'b0;
            nb++;
            if (!p) nm++;
            if (cnt != 2'b11) cnt = cnt + 2'b01;
            if (!p) begin
                instr_F = J_BACK;
                @(negedge clk);
            end
        end
        n_checks++;
        if (dut.bht[0] !== 2'b11) begin
            n_fail++;
            $display("FAIL train_sat: got %b exp 11", dut.bht[0]);
        end
        n_checks++;
        if (branch_cnt !== 32'(nb) || mispred_cnt !== 32'(nm)) begin
            n_fail++;
            $display("FAIL train_cnt: got %0d/%0d exp %0d/%0d",
                     branch_cnt, mispred_cnt, nb, nm);
        end
    endtask

    task automatic test_nt_mispredict();
        instr_F = BEQ3;
        @(negedge clk);
        instr_F  = NOP;
        branch_D = 1'b1;
        taken_D  = 1'b0;
        #1;
        n_checks++;
        if (flush_F !== 1'b1) begin
            n_fail++;
            $display("FAIL nt_flush: got %b exp 1", flush_F);
        end
        @(negedge clk);
        branch_D = 1'b0;
        n_checks++;
        if (PC_F !== 32'h3004 || dut.bht[0] !== 2'b10) begin
            n_fail++;
            $display("FAIL nt_redirect: pc %h bht %b exp 00003004 10", PC_F, dut.bht[0]);
        end
        instr_F = BNE_M2;
        #1;
        n_checks++;
        if (pred_taken_F !== 1'b0) begin
            n_fail++;
            $display("FAIL neg_pred: got %b exp 0", pred_taken_F);
        end
        @(negedge clk);
        instr_F  = NOP;
        branch_D = 1'b1;
        taken_D  = 1'b1;
        @(negedge clk);
        branch_D = 1'b0;
        taken_D  = 1'b0;
        n_checks++;
        if (PC_F !== 32'h3000 || dut.bht[1] !== 2'b10) begin
            n_fail++;
            $display("FAIL neg_target: pc %h bht1 %b exp 00003000 10", PC_F, dut.bht[1]);
        end
        n_checks++;
        if (branch_cnt !== 7 || mispred_cnt !== 3) begin
            n_fail++;
            $display("FAIL nt_cnt: got %0d/%0d exp 7/3", branch_cnt, mispred_cnt);
        end
    endtask

    task automatic test_stall();
        do_reset();
        instr_F = BEQ3;
        @(negedge clk);
        instr_F  = NOP;
        branch_D = 1'b1;
        taken_D  = 1'b1;
        stall    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (flush_F !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_flush[%0d]: got %b exp 0", i, flush_F);
            end
            @(negedge clk);
            n_checks++;
            if (PC_F !== 32'h3004 || branch_cnt !== 0 || dut.bht[0] !== 2'b01) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: pc %h cnt %0d bht %b exp 00003004 0 01",
                         i, PC_F, branch_cnt, dut.bht[0]);
            end
        end
        stall = 1'b0;
        #1;
        n_checks++;
        if (flush_F !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_release: got %b exp 1", flush_F);
        end
        @(negedge clk);
        branch_D = 1'b0;
        taken_D  = 1'b0;
        n_checks++;
        if (PC_F !== 32'h3010 || dut.bht[0] !== 2'b10) begin
            n_fail++;
            $display("FAIL stall_upd: pc %h bht %b exp 00003010 10", PC_F, dut.bht[0]);
        end
        @(negedge clk);
        n_checks++;
        if (branch_cnt !== 1 || mispred_cnt !== 1) begin
            n_fail++;
            $display("FAIL stall_cnt: got %0d/%0d exp 1/1", branch_cnt, mispred_cnt);
        end
    endtask

    task automatic test_jr_reset();
        int bad;
        instr_F = J_BACK;
        @(negedge clk);
        instr_F = BEQ3;
        jr_D    = 1'b1;
        RD1     = 32'h0000_4000;
        #1;
        n_checks++;
        if (pred_taken_F !== 1'b1 || flush_F !== 1'b1) begin
            n_fail++;
            $display("FAIL jr_comb: pred %b flush %b exp 1 1", pred_taken_F, flush_F);
        end
        @(negedge clk);
        jr_D = 1'b0;
        n_checks++;
        if (PC_F !== 32'h0000_4000) begin
            n_fail++;
            $display("FAIL jr_target: got %h exp 00004000", PC_F);
        end
        instr_F  = NOP;
        branch_D = 1'b1;
        taken_D  = 1'b0;
        #1;
        n_checks++;
        if (flush_F !== 1'b0) begin
            n_fail++;
            $display("FAIL jr_squash: got %b exp 0", flush_F);
        end
        @(negedge clk);
        branch_D = 1'b0;
        n_checks++;
        if (PC_F !== 32'h4004 || branch_cnt !== 1 || dut.bht[0] !== 2'b10) begin
            n_fail++;
            $display("FAIL jr_notrain: pc %h cnt %0d bht %b exp 00004004 1 10",
                     PC_F, branch_cnt, dut.bht[0]);
        end
        reset = 1'b1;
        #1;
        bad = 0;
        for (int i = 0; i < 64; i++)
            if (dut.bht[i] !== 2'b01) bad++;
        n_checks++;
        if (PC_F !== 32'h3000 || bad != 0 || branch_cnt !== 0 || mispred_cnt !== 0) begin
            n_fail++;
            $display("FAIL mid_reset: pc %h bad_bht %0d cnt %0d/%0d exp 00003000 0 0/0",
                     PC_F, bad, branch_cnt, mispred_cnt);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if (PC_F !== 32'h3000) begin
            n_fail++;
            $display("FAIL reset_release: got %h exp 00003000", PC_F);
        end
        @(negedge clk);
        n_checks++;
        if (PC_F !== 32'h3004) begin
            n_fail++;
            $display("FAIL reset_resume: got %h exp 00003004", PC_F);
        end
    endtask

    initial begin
        test_reset();
        test_nop_stream();
        test_jump();
        test_mispredict();
        test_train();
        test_nt_mispredict();
        test_stall();
        test_jr_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/npc_predict_unit.md
Name: npc_predict_unit

Overview:
- Next-generation next-PC unit for the 5-stage MIPS pipeline, with no branch delay slot.
- Owns the fetch PC register and pre-decodes the F-stage instruction.
- Predicts beq/bne outcomes with a parametrised table of 2-bit saturating counters (BHT), and follows j/jal in F with zero penalty.
- Resolves branches and jr in D: redirects fetch, squashes the wrong-path F instruction, trains the BHT, and keeps branch/mispredict statistics.

Parameters:
- WIDTH, 32, PC and register width (≥ 28).
- BHT_ENTRIES, 64, number of BHT counters; power of 2, 2..1024.
- RESET_PC, 32'h0000_3000, fetch address after reset.
- CNT_INIT, 2'b01, counter value after reset (weakly not-taken).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- instr_F  in  32  instruction fetched at PC_F.
- stall  in  1  hazard stall: hold PC_F and the D-stage tracking state.
- branch_D  in  1  instruction in D is beq/bne.
- taken_D  in  1  D-stage comparison result; valid when branch_D=1.
- jr_D  in  1  instruction in D is jr/jalr.
- RD1  in  WIDTH  forwarded rs value, used as the jr target.
- PC_F  out  WIDTH  current fetch address.
- flush_F  out  1  combinational; F/D register must load a bubble at the next edge.
- pred_taken_F  out  1  combinational prediction for instr_F (debug).
- branch_cnt  out  32  resolved conditional branches.
- mispred_cnt  out  32  resolved mispredicted conditional branches.

Behaviour:
- **Reset (async):**
  - PC_F=RESET_PC; all BHT entries=CNT_INIT.
  - valid_D=0, pred_D=0, pc_D=0, off_D=0.
  - Both counters=0; flush_F=0.
- **Index:** idx = pc[log2(BHT_ENTRIES)+1:2]. seq = PC_F+4. Offset = sign-extended imm16 shifted left 2, computed at WIDTH bits; adds wrap modulo 2^WIDTH.
- **F pre-decode, by opcode instr_F[31:26]:**
  - 000100/000101 (beq/bne): pred_taken_F = BHT[idx(PC_F)][1]; npred = seq+offset if predicted taken, else seq.
  - 000010/000011 (j/jal): npred = {seq[WIDTH-1:28], instr_F[25:0], 2'b00}; pred_taken_F=0.
  - Otherwise: npred = seq; pred_taken_F=0.
- **D tracking registers (valid_D, pc_D, off_D, pred_D):**
  - Load from F on every edge with stall=0.
  - valid_D=1 only if instr_F was beq/bne and flush_F=0; otherwise 0.
  - Hold when stall=1.
- **Resolution (combinational):** res = valid_D & branch_D & ~stall.
  - mis = res & (taken_D != pred_D).
  - jr_r = jr_D & ~stall.
- **Next PC, priority high to low:**
  1. stall=1 → hold.
  2. jr_r → RD1.
  3. mis & taken_D → pc_D+4+off_D.
  4. mis & ~taken_D → pc_D+4.
  5. otherwise → npred.
- **flush_F** = jr_r | mis.
  - jr always costs one bubble; no prediction for jr.
  - branch_D=1 with valid_D=0 is a decoder/flush inconsistency: treat as resolved-correct, no update.
- **BHT update:** on edge with res=1, BHT[idx(pc_D)] saturating +1 if taken_D, −1 otherwise (00 and 11 stick). Exactly one update per branch, because stalled cycles do not update.
- **Counters:**
  - branch_cnt += 1 on res.
  - mispred_cnt += 1 on mis.
  - Both wrap at 2^32.
- **Simultaneous events:**
  - A D redirect overrides the F prediction and F-stage j.
  - The flushed F instruction never trains the BHT.
- **Reset mid-operation:** immediate return to reset state; PC_F=RESET_PC on the first edge after deassertion is unchanged.

Test Plan:
1. Reset, stream of NOPs, no stalls → PC_F 0x3000, 0x3004, 0x3008…; flush_F never 1; both counters 0.
2. instr_F=j 0x0000C10 at PC_F=0x3000 → next PC_F=0x00003040; no flush.
3. beq imm=+3 at 0x3000 with BHT=01 (predict NT); next cycle branch_D=1, taken_D=1 → flush_F=1; PC_F becomes 0x3010; BHT[0]=10; branch_cnt=1, mispred_cnt=1.
4. Same beq re-executed four times, all taken → second pass predicted taken (PC_F 0x3000→0x3010, no flush); BHT saturates at 11 with no wrap; mispred_cnt stays 1.
5. Branch resolving with stall=1 for 3 cycles, then 0 → PC_F held; exactly one BHT update and one branch_cnt increment, both on the release edge.
6. jr_D=1, RD1=0x00004000, concurrent F beq predicted taken → PC_F=0x4000; flush_F=1; F prediction discarded; then assert reset mid-run → PC_F=0x3000 and all BHT entries = CNT_INIT.
